// File: rtl/reg_pkg.sv
// Register-interface request/response types shared by register-bus initiators and targets.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/sap_pkg.sv
// System-level OBI types and defaults used by the crossbar-facing bridges.
package sap_pkg;

  localparam int unsigned DEFAULT_REG2OBI_TIMEOUT = 256;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_to_obi_master.sv
// Register-bus to OBI master bridge: one OBI transaction per register access, with a
// cycle budget that forces an error reply and then drains the orphaned OBI transaction.
module reg_to_obi_master
  import sap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_REG2OBI_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_pkg::reg_req_t reg_req_i,
  output reg_pkg::reg_rsp_t reg_rsp_o,
  output obi_req_t          obi_req_o,
  input  obi_resp_t         obi_resp_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StReply,
    StToAddr,
    StToData,
    StDrainAddr,
    StDrainData
  } state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  obi_req_t          r_obi;
  reg_pkg::reg_rsp_t r_rsp;
  logic              w_expired;

  // Saturating compare: a grant on the last budget cycle leaves the data phase already spent,
  // so the following cycle without rvalid still times out.
  assign w_expired = (TIMEOUT_CYCLES != 0) && (r_cnt >= CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_obi   <= '0;
      r_rsp   <= '0;
    end else begin
      r_rsp <= '0;
      case (r_state)
        StIdle: begin
          if (reg_req_i.valid) begin
            r_obi.req   <= 1'b1;
            r_obi.we    <= reg_req_i.write;
            r_obi.be    <= reg_req_i.write ? reg_req_i.wstrb : 4'hF;
            r_obi.addr  <= reg_req_i.addr;
            r_obi.wdata <= reg_req_i.wdata;
            r_cnt       <= '0;
            r_state     <= StAddr;
          end
        end
        StAddr: begin
          r_cnt <= r_cnt + 1'b1;
          if (obi_resp_i.gnt) begin
            r_obi.req <= 1'b0;
            r_state   <= StData;
          end else if (w_expired) begin
            r_rsp.ready <= 1'b1;
            r_rsp.error <= 1'b1;
            r_state     <= StToAddr;
          end
        end
        StData: begin
          r_cnt <= r_cnt + 1'b1;
          if (obi_resp_i.rvalid) begin
            r_rsp.ready <= 1'b1;
            r_rsp.rdata <= r_obi.we ? 32'h0 : obi_resp_i.rdata;
            r_rsp.error <= 1'b0;
            r_state     <= StReply;
          end else if (w_expired) begin
            r_rsp.ready <= 1'b1;
            r_rsp.error <= 1'b1;
            r_state     <= StToData;
          end
        end
        StReply: begin
          r_state <= StIdle;
        end
        // Request must stay up until granted, even though the register side has been answered.
        StToAddr: begin
          if (obi_resp_i.gnt) begin
            r_obi.req <= 1'b0;
            r_state   <= StDrainData;
          end else begin
            r_state <= StDrainAddr;
          end
        end
        StToData: begin
          r_state <= obi_resp_i.rvalid ? StIdle : StDrainData;
        end
        StDrainAddr: begin
          if (obi_resp_i.gnt) begin
            r_obi.req <= 1'b0;
            r_state   <= StDrainData;
          end
        end
        StDrainData: begin
          if (obi_resp_i.rvalid) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign obi_req_o = r_obi;
  assign reg_rsp_o = r_rsp;

endmodule

// File: tb/tb_reg_to_obi_master.sv
// Cycle-table bench for reg_to_obi_master: per-cycle stimulus arrays, recorded outputs,
// and expectations derived from the bridge's latency and timeout rules.
module tb_reg_to_obi_master;
  import sap_pkg::*;
  import reg_pkg::*;

  localparam int unsigned N = 16;
  localparam int MAXC = 64;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  reg_req_t  reg_req;
  reg_rsp_t  reg_rsp;
  obi_req_t  obi_req;
  obi_resp_t obi_resp;

  reg_to_obi_master #(.TIMEOUT_CYCLES(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (reg_req),
    .reg_rsp_o (reg_rsp),
    .obi_req_o (obi_req),
    .obi_resp_i(obi_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  reg_req_t  s_req[MAXC];
  obi_resp_t s_rsp[MAXC];
  logic      s_rst[MAXC];
  obi_req_t  o_obi[MAXC];
  reg_rsp_t  o_rsp[MAXC];

  function automatic obi_req_t exp_obi(input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] st);
    obi_req_t o;
    o.req   = 1'b1;
    o.we    = wr;
    o.be    = wr ? st : 4'hF;
    o.addr  = a;
    o.wdata = d;
    return o;
  endfunction

  function automatic reg_rsp_t mk_rsp(input logic rdy, input logic [31:0] d, input logic err);
    reg_rsp_t r;
    r.ready = rdy;
    r.rdata = d;
    r.error = err;
    return r;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      s_req[i] = '0;
      s_rsp[i] = '0;
      s_rst[i] = 1'b0;
    end
  endtask

  task automatic hold_req(input int from, input int to, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
    for (int t = from; t <= to; t++) begin
      s_req[t].valid = 1'b1;
      s_req[t].write = wr;
      s_req[t].addr  = a;
      s_req[t].wdata = d;
      s_req[t].wstrb = st;
    end
  endtask

  task automatic pulse_gnt(input int t);
    s_rsp[t].gnt = 1'b1;
  endtask

  task automatic pulse_rv(input int t, input logic [31:0] d);
    s_rsp[t].rvalid = 1'b1;
    s_rsp[t].rdata  = d;
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      rst      = s_rst[t];
      reg_req  = s_req[t];
      obi_resp = s_rsp[t];
      @(negedge clk);
      o_obi[t] = obi_req;
      o_rsp[t] = reg_rsp;
    end
  endtask

  task automatic test_reset();
    reg_req  = '0;
    obi_resp = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obi_req !== '0) begin
      n_fail++; $display("FAIL reset_obi got %h exp %h", obi_req, obi_req_t'('0));
    end
    n_checks++;
    if (reg_rsp !== '0) begin
      n_fail++; $display("FAIL reset_rsp got %h exp %h", reg_rsp, reg_rsp_t'('0));
    end
  endtask

  task automatic test_basic_read();
    obi_req_t e;
    clear_stim();
    hold_req(0, 3, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    pulse_gnt(1);
    pulse_rv(2, 32'hDEAD_BEEF);
    run(6);
    e = exp_obi(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    n_checks++;
    if (o_obi[0].req !== 1'b0) begin n_fail++; $display("FAIL rd_req_c0 got %b exp 0", o_obi[0].req); end
    n_checks++;
    if (o_obi[1] !== e) begin n_fail++; $display("FAIL rd_obi_c1 got %h exp %h", o_obi[1], e); end
    n_checks++;
    if (o_obi[2].req !== 1'b0) begin n_fail++; $display("FAIL rd_req_c2 got %b exp 0", o_obi[2].req); end
    n_checks++;
    if (o_rsp[2] !== '0) begin n_fail++; $display("FAIL rd_rsp_c2 got %h exp 0", o_rsp[2]); end
    n_checks++;
    if (o_rsp[3] !== mk_rsp(1'b1, 32'hDEAD_BEEF, 1'b0)) begin
      n_fail++; $display("FAIL rd_rsp_c3 got %h exp %h", o_rsp[3], mk_rsp(1'b1, 32'hDEAD_BEEF, 1'b0));
    end
    n_checks++;
    if (o_rsp[4].ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_c4 got %b exp 0", o_rsp[4].ready); end
  endtask

  task automatic test_write_stall();
    logic [31:0] a;
    obi_req_t    e;
    a = $urandom & 32'hFFFF_FFFC;
    clear_stim();
    hold_req(0, 8, 1'b1, a, 32'h1234_5678, 4'b0011);
    pulse_gnt(6);
    pulse_rv(7, 32'hA5A5_A5A5);
    run(10);
    e = exp_obi(1'b1, a, 32'h1234_5678, 4'b0011);
    for (int t = 1; t <= 6; t++) begin
      n_checks++;
      if (o_obi[t] !== e) begin n_fail++; $display("FAIL wr_obi_c%0d got %h exp %h", t, o_obi[t], e); end
    end
    n_checks++;
    if (o_obi[7].req !== 1'b0) begin n_fail++; $display("FAIL wr_req_c7 got %b exp 0", o_obi[7].req); end
    n_checks++;
    if (o_rsp[7].ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_c7 got %b exp 0", o_rsp[7].ready); end
    n_checks++;
    if (o_rsp[8] !== mk_rsp(1'b1, 32'h0, 1'b0)) begin
      n_fail++; $display("FAIL wr_rsp_c8 got %h exp %h", o_rsp[8], mk_rsp(1'b1, 32'h0, 1'b0));
    end
  endtask

  task automatic test_timeout_addr();
    logic [31:0] b, x;
    obi_req_t    ea, eb;
    int          nrdy;
    b = $urandom & 32'hFFFF_FFFC;
    x = $urandom;
    clear_stim();
    hold_req(0, 17, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
    hold_req(20, 35, 1'b0, b, 32'h0, 4'h0);
    pulse_gnt(30);
    pulse_rv(31, 32'hBAD0_BAD0);
    pulse_gnt(33);
    pulse_rv(34, x);
    run(38);
    ea = exp_obi(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    eb = exp_obi(1'b0, b, 32'h0, 4'h0);
    n_checks++;
    if (o_rsp[16] !== '0) begin n_fail++; $display("FAIL toa_rsp_c16 got %h exp 0", o_rsp[16]); end
    n_checks++;
    if (o_rsp[17] !== mk_rsp(1'b1, 32'h0, 1'b1)) begin
      n_fail++; $display("FAIL toa_err_c17 got %h exp %h", o_rsp[17], mk_rsp(1'b1, 32'h0, 1'b1));
    end
    n_checks++;
    if (o_obi[17] !== ea) begin n_fail++; $display("FAIL toa_obi_c17 got %h exp %h", o_obi[17], ea); end
    n_checks++;
    if (o_obi[30] !== ea) begin n_fail++; $display("FAIL toa_obi_c30 got %h exp %h", o_obi[30], ea); end
    n_checks++;
    if ((o_obi[31].req | o_obi[32].req) !== 1'b0) begin
      n_fail++; $display("FAIL toa_req_c31_32 got %b%b exp 00", o_obi[31].req, o_obi[32].req);
    end
    nrdy = 0;
    for (int t = 18; t <= 34; t++) if (o_rsp[t].ready === 1'b1) nrdy++;
    n_checks++;
    if (nrdy !== 0) begin n_fail++; $display("FAIL toa_spurious_ready got %0d exp 0", nrdy); end
    n_checks++;
    if (o_obi[33] !== eb) begin n_fail++; $display("FAIL toa_next_obi_c33 got %h exp %h", o_obi[33], eb); end
    n_checks++;
    if (o_rsp[35] !== mk_rsp(1'b1, x, 1'b0)) begin
      n_fail++; $display("FAIL toa_next_rsp_c35 got %h exp %h", o_rsp[35], mk_rsp(1'b1, x, 1'b0));
    end
  endtask

  task automatic test_timeout_data();
    logic [31:0] b, x;
    obi_req_t    eb;
    int          nrdy;
    b = $urandom & 32'hFFFF_FFFC;
    x = $urandom;
    clear_stim();
    hold_req(0, 17, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    hold_req(20, 44, 1'b0, b, 32'h0, 4'h0);
    pulse_gnt(2);
    pulse_rv(40, 32'hBAD1_BAD1);
    pulse_gnt(42);
    pulse_rv(43, x);
    run(47);
    eb = exp_obi(1'b0, b, 32'h0, 4'h0);
    n_checks++;
    if ({o_obi[2].req, o_obi[3].req} !== 2'b10) begin
      n_fail++; $display("FAIL tod_req_c2_3 got %b%b exp 10", o_obi[2].req, o_obi[3].req);
    end
    n_checks++;
    if (o_rsp[16] !== '0) begin n_fail++; $display("FAIL tod_rsp_c16 got %h exp 0", o_rsp[16]); end
    n_checks++;
    if (o_rsp[17] !== mk_rsp(1'b1, 32'h0, 1'b1)) begin
      n_fail++; $display("FAIL tod_err_c17 got %h exp %h", o_rsp[17], mk_rsp(1'b1, 32'h0, 1'b1));
    end
    nrdy = 0;
    for (int t = 18; t <= 43; t++) if (o_rsp[t].ready === 1'b1) nrdy++;
    n_checks++;
    if (nrdy !== 0) begin n_fail++; $display("FAIL tod_spurious_ready got %0d exp 0", nrdy); end
    n_checks++;
    if (o_obi[41].req !== 1'b0) begin n_fail++; $display("FAIL tod_req_c41 got %b exp 0", o_obi[41].req); end
    n_checks++;
    if (o_obi[42] !== eb) begin n_fail++; $display("FAIL tod_next_obi_c42 got %h exp %h", o_obi[42], eb); end
    n_checks++;
    if (o_rsp[44] !== mk_rsp(1'b1, x, 1'b0)) begin
      n_fail++; $display("FAIL tod_next_rsp_c44 got %h exp %h", o_rsp[44], mk_rsp(1'b1, x, 1'b0));
    end
  endtask

  task automatic test_coincide();
    logic [31:0] x1, x2;
    x1 = $urandom;
    x2 = $urandom;
    // Grant lands on the last budget cycle.
    clear_stim();
    hold_req(0, 18, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
    pulse_gnt(N);
    pulse_rv(N + 1, x1);
    run(20);
    n_checks++;
    if (o_rsp[17] !== '0) begin n_fail++; $display("FAIL co_gnt_rsp_c17 got %h exp 0", o_rsp[17]); end
    n_checks++;
    if (o_rsp[18] !== mk_rsp(1'b1, x1, 1'b0)) begin
      n_fail++; $display("FAIL co_gnt_rsp_c18 got %h exp %h", o_rsp[18], mk_rsp(1'b1, x1, 1'b0));
    end
    n_checks++;
    if (o_rsp[19].ready !== 1'b0) begin n_fail++; $display("FAIL co_gnt_ready_c19 got %b exp 0", o_rsp[19].ready); end
    // Read data lands on the last budget cycle.
    clear_stim();
    hold_req(0, 17, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
    pulse_gnt(1);
    pulse_rv(N, x2);
    run(19);
    n_checks++;
    if (o_rsp[16] !== '0) begin n_fail++; $display("FAIL co_rv_rsp_c16 got %h exp 0", o_rsp[16]); end
    n_checks++;
    if (o_rsp[17] !== mk_rsp(1'b1, x2, 1'b0)) begin
      n_fail++; $display("FAIL co_rv_rsp_c17 got %h exp %h", o_rsp[17], mk_rsp(1'b1, x2, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b, y;
    obi_req_t    eb;
    int          nrdy, nreq;
    b = $urandom & 32'hFFFF_FFFC;
    y = $urandom;
    clear_stim();
    hold_req(0, 1, 1'b0, 32'h0000_7000, 32'h0, 4'h0);
    pulse_gnt(1);
    s_rst[2] = 1'b1;
    pulse_rv(4, 32'hBAD2_BAD2);
    hold_req(9, 12, 1'b0, b, 32'h0, 4'h0);
    pulse_gnt(10);
    pulse_rv(11, y);
    run(14);
    eb = exp_obi(1'b0, b, 32'h0, 4'h0);
    n_checks++;
    if (o_obi[2] !== '0) begin n_fail++; $display("FAIL rstm_obi_c2 got %h exp 0", o_obi[2]); end
    n_checks++;
    if (o_rsp[2] !== '0) begin n_fail++; $display("FAIL rstm_rsp_c2 got %h exp 0", o_rsp[2]); end
    nrdy = 0;
    nreq = 0;
    for (int t = 3; t <= 11; t++) if (o_rsp[t].ready === 1'b1) nrdy++;
    for (int t = 3; t <= 9; t++) if (o_obi[t].req === 1'b1) nreq++;
    n_checks++;
    if (nrdy !== 0) begin n_fail++; $display("FAIL rstm_stray_ready got %0d exp 0", nrdy); end
    n_checks++;
    if (nreq !== 0) begin n_fail++; $display("FAIL rstm_stray_req got %0d exp 0", nreq); end
    n_checks++;
    if (o_obi[10] !== eb) begin n_fail++; $display("FAIL rstm_obi_c10 got %h exp %h", o_obi[10], eb); end
    n_checks++;
    if (o_rsp[12] !== mk_rsp(1'b1, y, 1'b0)) begin
      n_fail++; $display("FAIL rstm_rsp_c12 got %h exp %h", o_rsp[12], mk_rsp(1'b1, y, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    localparam int K = 6;
    obi_req_t eo[K];
    reg_rsp_t er[K];
    clear_stim();
    for (int i = 0; i < K; i++) begin
      logic        wr;
      logic [31:0] a, d, rv;
      logic [3:0]  st;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      rv = $urandom;
      st = 4'($urandom);
      hold_req(4 * i, 4 * i + 3, wr, a, d, st);
      pulse_gnt(4 * i + 1);
      pulse_rv(4 * i + 2, rv);
      eo[i] = exp_obi(wr, a, d, st);
      er[i] = mk_rsp(1'b1, wr ? 32'h0 : rv, 1'b0);
    end
    run(4 * K + 2);
    for (int i = 0; i < K; i++) begin
      n_checks++;
      if (o_obi[4 * i + 1] !== eo[i]) begin
        n_fail++; $display("FAIL b2b_obi_%0d got %h exp %h", i, o_obi[4 * i + 1], eo[i]);
      end
      n_checks++;
      if (o_rsp[4 * i + 3] !== er[i]) begin
        n_fail++; $display("FAIL b2b_rsp_%0d got %h exp %h", i, o_rsp[4 * i + 3], er[i]);
      end
    end
  endtask

  task automatic test_random_latency();
    for (int k = 0; k < 10; k++) begin
      int          g, r, e, first;
      logic        wr;
      logic [31:0] a, d, rv;
      logic [3:0]  st;
      obi_req_t    eo;
      reg_rsp_t    er;
      g  = int'($urandom_range(0, 5));
      r  = int'($urandom_range(0, 5));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      rv = $urandom;
      st = 4'($urandom);
      e  = g + r + 3;
      clear_stim();
      hold_req(0, e, wr, a, d, st);
      pulse_gnt(1 + g);
      pulse_rv(2 + g + r, rv);
      run(e + 2);
      eo = exp_obi(wr, a, d, st);
      er = mk_rsp(1'b1, wr ? 32'h0 : rv, 1'b0);
      for (int t = 1; t <= 1 + g; t++) begin
        n_checks++;
        if (o_obi[t] !== eo) begin n_fail++; $display("FAIL rnd%0d_obi_c%0d got %h exp %h", k, t, o_obi[t], eo); end
      end
      first = -1;
      for (int t = e + 1; t >= 0; t--) if (o_rsp[t].ready === 1'b1) first = t;
      n_checks++;
      if (first !== e) begin n_fail++; $display("FAIL rnd%0d_ready_cycle got %0d exp %0d", k, first, e); end
      n_checks++;
      if (o_rsp[e] !== er) begin n_fail++; $display("FAIL rnd%0d_rsp got %h exp %h", k, o_rsp[e], er); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_stall();
    test_timeout_addr();
    test_timeout_data();
    test_coincide();
    test_reset_mid();
    test_back_to_back();
    test_random_latency();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
